// File: rtl/adma_wbm_ram_if.sv
// Wishbone master-port bundle between the ADMA engine and its responder RAM.
// Signal names follow the engine side, so the RAM's outputs end in _i.
interface adma_wbm_ram_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_cab_o;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat64_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic [31:0] wbm_dat_i;
    logic [31:0] wbm_dat64_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_adr_o,
               wbm_sel_o, wbm_dat_o, wbm_dat64_o,
        input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_adr_o,
               wbm_sel_o, wbm_dat_o, wbm_dat64_o,
        output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
    );
endinterface

// File: rtl/adma_wbm_ram.sv
// 64-bit Wishbone responder RAM for the ADMA master port: wait states, cab bursts
// with next-word prefetch, error/retry injection, and a host preload port.
module adma_wbm_ram #(
    parameter int unsigned AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    adma_wbm_ram_if.slave wbm,
    input  logic          rty_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_adr,
    input  logic [63:0]   ld_dat
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_BURST} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] pref_word;
    logic          ack_q, err_q, rty_q;
    logic [63:0]   rd_q;
    logic [63:0]   mem [0:(1<<AW)-1];

    logic          req, in_range, burst_hit, wr_en, start, respond;
    logic [AW-1:0] word, word_inc, rd_word;
    logic [63:0]   wr_data, rd_data;
    logic          unused_adr;

    assign unused_adr = ^wbm.wbm_adr_o[2:0];

    always_comb begin
        req       = wbm.wbm_cyc_o & wbm.wbm_stb_o;
        word      = wbm.wbm_adr_o[AW+2:3];
        word_inc  = word + AW'(1);
        in_range  = (wbm.wbm_adr_o[31:AW+3] == BASE_ADDR[31:AW+3]);
        // A burst beat is acked in the same cycle only if it lands on the prefetched word.
        burst_hit = (state == S_BURST) & req & in_range & (word == pref_word);
        wr_en     = req & wbm.wbm_we_o & (((state == S_RESP) & ack_q) | burst_hit);
        wr_data   = mem[word];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wbm.wbm_sel_o[i]) begin
                wr_data[8*i +: 8]    = wbm.wbm_dat_o[8*i +: 8];
                wr_data[32+8*i +: 8] = wbm.wbm_dat64_o[8*i +: 8];
            end
        end
        rd_word = ((state == S_RESP) | burst_hit) ? word_inc : word;
        rd_data = (wr_en && (rd_word == word)) ? wr_data : mem[rd_word];
        start   = req & ((state == S_IDLE) | ((state == S_BURST) & ~burst_hit));
        respond = (start & (WAIT_STATES == 0)) |
                  ((state == S_WAIT) & req & (wait_cnt <= 4'd1));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            pref_word <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            if (respond) begin
                state <= S_RESP;
                if (!in_range) begin
                    err_q <= 1'b1;
                end else if (rty_req) begin
                    rty_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    rd_q  <= rd_data;
                end
            end else if (start) begin
                state    <= S_WAIT;
                wait_cnt <= 4'(WAIT_STATES);
            end else begin
                case (state)
                    S_WAIT: begin
                        if (!req) state <= S_IDLE;
                        else      wait_cnt <= wait_cnt - 4'd1;
                    end
                    S_RESP: begin
                        if (ack_q & req & wbm.wbm_cab_o) begin
                            state     <= S_BURST;
                            pref_word <= word_inc;
                            rd_q      <= rd_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_BURST: begin
                        if (burst_hit & wbm.wbm_cab_o) begin
                            pref_word <= word_inc;
                            rd_q      <= rd_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Preload is applied last so it overrides a bus write to the same word.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) mem[word]   <= wr_data;
        if (ld_we) mem[ld_adr] <= ld_dat;
    end

    assign wbm.wbm_ack_i   = ack_q | burst_hit;
    assign wbm.wbm_err_i   = err_q;
    assign wbm.wbm_rty_i   = rty_q;
    assign wbm.wbm_dat_i   = rd_q[31:0];
    assign wbm.wbm_dat64_i = rd_q[63:32];
endmodule
